button_event_decoder: RTL and testbench



---
 rtl/button_event_pkg.sv | 20 ++
 rtl/edge_detector.sv | 36 +++
 rtl/button_event_decoder.sv | 107 ++++++++++
 tb/tb_button_event_decoder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/button_event_pkg.sv
// Shared constants for the push-button event decoder: FSM state codes and
// default timing at a 50 MHz system clock.
package button_event_pkg;

   localparam int unsigned STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
   localparam logic [STATE_W-1:0] ST_PRESS1    = 3'd1;
   localparam logic [STATE_W-1:0] ST_WAIT2     = 3'd2;
   localparam logic [STATE_W-1:0] ST_PRESS2    = 3'd3;
   localparam logic [STATE_W-1:0] ST_LONG_HELD = 3'd4;

   localparam int unsigned LONG_PRESS_CLKS_DEF = 50_000_000;
   localparam int unsigned DCLICK_GAP_CLKS_DEF = 15_000_000;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/edge_detector.sv
// Registered rise/fall strobes for a synchronous level. The level register
// loads the live input during reset so a level held through reset is no edge.
module edge_detector (
   input  logic clk,
   input  logic rst,
   input  logic lvl,
   output logic lvl_q,
   output logic rise_c,
   output logic fall_c,
   output logic rise_q,
   output logic fall_q
);

   logic rise_d;
   logic fall_d;

   assign rise_c = lvl & ~lvl_q;
   assign fall_c = ~lvl & lvl_q;

   always_comb begin
      rise_d = rise_c;
      fall_d = fall_c;
   end

   always_ff @(posedge clk) begin
      lvl_q <= lvl;
      if (rst) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into single-cycle press, release, click,
// double-click and long-press events.
module button_event_decoder
   import button_event_pkg::*;
#(
   parameter bit          ACTIVE_LOW      = 1'b1,
   parameter int unsigned LONG_PRESS_CLKS = LONG_PRESS_CLKS_DEF,
   parameter int unsigned DCLICK_GAP_CLKS = DCLICK_GAP_CLKS_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic pb_level,
   output logic pressed,
   output logic press_pulse,
   output logic release_pulse,
   output logic click_pulse,
   output logic double_pulse,
   output logic long_pulse
);

   localparam int unsigned CNT_W = $clog2(max_u(LONG_PRESS_CLKS, DCLICK_GAP_CLKS)) + 1;
   localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_PRESS_CLKS - 1);
   localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(DCLICK_GAP_CLKS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic               lvl_c;
   logic               rise_c;
   logic               fall_c;
   logic [STATE_W-1:0] state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               click_q, click_d;
   logic               double_q, double_d;
   logic               long_q, long_d;

   assign lvl_c = pb_level ^ ACTIVE_LOW;

   edge_detector u_edge (
      .clk    (clk),
      .rst    (rst),
      .lvl    (lvl_c),
      .lvl_q  (pressed),
      .rise_c (rise_c),
      .fall_c (fall_c),
      .rise_q (press_pulse),
      .fall_q (release_pulse)
   );

   // State register, timer and gesture strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         click_q  <= 1'b0;
         double_q <= 1'b0;
         long_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         click_q  <= click_d;
         double_q <= double_d;
         long_q   <= long_d;
      end
   end

   // Next state: an edge always takes priority over a timer limit
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:      if (rise_c) state_d = ST_PRESS1;
         ST_PRESS1: begin
            if (fall_c)                 state_d = ST_WAIT2;
            else if (cnt_q == LONG_LIM) state_d = ST_LONG_HELD;
         end
         ST_WAIT2: begin
            if (rise_c)                state_d = ST_PRESS2;
            else if (cnt_q == GAP_LIM) state_d = ST_IDLE;
         end
         ST_PRESS2: begin
            if (fall_c)                 state_d = ST_IDLE;
            else if (cnt_q == LONG_LIM) state_d = ST_LONG_HELD;
         end
         ST_LONG_HELD: if (fall_c) state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   // Timer and gesture strobes derived from the transition taken
   always_comb begin
      cnt_d    = cnt_q;
      click_d  = 1'b0;
      double_d = 1'b0;
      long_d   = 1'b0;
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if ((state_q inside {ST_PRESS1, ST_WAIT2, ST_PRESS2}) && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      click_d  = (state_q == ST_WAIT2)  && (state_d == ST_IDLE);
      double_d = (state_q == ST_PRESS2) && (state_d == ST_IDLE);
      long_d   = (state_q != ST_LONG_HELD) && (state_d == ST_LONG_HELD);
   end

   assign click_pulse  = click_q;
   assign double_pulse = double_q;
   assign long_pulse   = long_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder with LONG=8, GAP=5, active-high button:
// gesture table, hand-written reset sequences and a run-length reference model.
module tb_button_event_decoder;

   localparam int L    = 8;
   localparam int G    = 5;
   localparam int MAXN = 1024;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pb_level = 1'b0;
   logic pressed, press_pulse, release_pulse, click_pulse, double_pulse, long_pulse;

   int total = 0;
   int bad   = 0;

   button_event_decoder #(
      .ACTIVE_LOW      (1'b0),
      .LONG_PRESS_CLKS (L),
      .DCLICK_GAP_CLKS (G)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .pb_level      (pb_level),
      .pressed       (pressed),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .click_pulse   (click_pulse),
      .double_pulse  (double_pulse),
      .long_pulse    (long_pulse)
   );

   always #5 clk = ~clk;

   typedef struct {
      string name;
      int    hi1, lo1, hi2;
      int    n_press, n_rel, n_click, n_dbl, n_long, first_at;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, act, exp);
      end
   endtask

   // Apply inputs just after an edge; outputs read 1 ns after the next edge
   task automatic step(input logic r, input logic l);
      rst = r;
      pb_level = l;
      @(posedge clk);
      #1;
   endtask

   // Reference data for the randomized section
   bit lv[MAXN];
   bit e_press[MAXN], e_rel[MAXN], e_click[MAXN], e_dbl[MAXN], e_long[MAXN];
   int n;

   task automatic build_model();
      int rs[$];
      int rl[$];
      bit rv[$];
      int i, r, h, f, g, r2, h2;
      bit prev;
      for (int t = 0; t < n; t++) begin
         prev = (t == 0) ? 1'b0 : lv[t-1];
         e_press[t] = lv[t] && !prev;
         e_rel[t]   = !lv[t] && prev;
         e_click[t] = 0; e_dbl[t] = 0; e_long[t] = 0;
      end
      // Split the level trace into runs of constant value
      for (int t = 0; t < n; t++) begin
         if (t == 0 || lv[t] != lv[t-1]) begin
            rs.push_back(t); rl.push_back(1); rv.push_back(lv[t]);
         end else begin
            rl[rl.size()-1] = rl[rl.size()-1] + 1;
         end
      end
      // Classify each gesture from its run lengths
      i = 0;
      while (i < rs.size()) begin
         if (!rv[i]) begin i++; continue; end
         r = rs[i]; h = rl[i];
         if (h >= L + 1) begin
            if (r + L < n) e_long[r+L] = 1;
            i++; continue;
         end
         if (i + 1 >= rs.size()) break;
         f = r + h; g = rl[i+1];
         if (g >= G + 1) begin
            if (f + G < n) e_click[f+G] = 1;
            i += 2; continue;
         end
         if (i + 2 >= rs.size()) break;
         r2 = rs[i+2]; h2 = rl[i+2];
         if (h2 >= L + 1) begin
            if (r2 + L < n) e_long[r2+L] = 1;
         end else if (r2 + h2 < n) begin
            e_dbl[r2+h2] = 1;
         end
         i += 3;
      end
   endtask

   initial begin
      int np, nr, nc, nd, nl, first_at, win, seen, len;
      bit l;

      vecs[0] = '{"click",       3, 0,  0, 1, 1, 1, 0, 0,  8};
      vecs[1] = '{"double",      3, 2,  3, 2, 2, 0, 1, 0,  8};
      vecs[2] = '{"long",       12, 0,  0, 1, 1, 0, 0, 1,  8};
      vecs[3] = '{"hold_at_thr", 8, 0,  0, 1, 1, 1, 0, 0, 13};
      vecs[4] = '{"gap_limit",   3, 5,  3, 2, 2, 0, 1, 0, 11};
      vecs[5] = '{"gap_over",    3, 6,  3, 2, 2, 2, 0, 0,  8};
      vecs[6] = '{"long_second", 2, 1, 10, 2, 2, 0, 0, 1, 11};
      vecs[7] = '{"second_thr",  2, 1,  8, 2, 2, 0, 1, 0, 11};
      vecs[8] = '{"hold9",       9, 0,  0, 1, 1, 0, 0, 1,  8};
      vecs[9] = '{"quick_dbl",   1, 1,  1, 2, 2, 0, 1, 0,  3};

      // Button held through reset: no edge, no pulses afterwards
      for (int k = 0; k < 3; k++) step(1'b1, 1'b1);
      check("rst_pressed", pressed, 1);
      check("rst_pulses", {press_pulse, release_pulse, click_pulse, double_pulse, long_pulse}, 0);
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         step(1'b0, 1'b1);
         seen += press_pulse + release_pulse + click_pulse + double_pulse + long_pulse;
      end
      check("held_thru_rst_pulses", seen, 0);
      check("held_thru_rst_pressed", pressed, 1);
      step(1'b0, 1'b0);
      check("first_release", release_pulse, 1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      check("press_after_rise", press_pulse, 1);
      step(1'b0, 1'b1);
      check("press_one_cycle", press_pulse, 0);
      for (int k = 0; k < 20; k++) step(1'b0, 1'b0);

      // Gesture table
      foreach (vecs[v]) begin
         np = 0; nr = 0; nc = 0; nd = 0; nl = 0; first_at = -1;
         win = vecs[v].hi1 + vecs[v].lo1 + vecs[v].hi2 + 20;
         for (int c = 0; c < win; c++) begin
            l = (c < vecs[v].hi1) ||
                (vecs[v].hi2 > 0 && c >= vecs[v].hi1 + vecs[v].lo1 &&
                 c < vecs[v].hi1 + vecs[v].lo1 + vecs[v].hi2);
            step(1'b0, l);
            np += press_pulse; nr += release_pulse;
            nc += click_pulse; nd += double_pulse; nl += long_pulse;
            if (first_at < 0 && (click_pulse || double_pulse || long_pulse)) first_at = c;
         end
         check($sformatf("%s.press", vecs[v].name), np, vecs[v].n_press);
         check($sformatf("%s.release", vecs[v].name), nr, vecs[v].n_rel);
         check($sformatf("%s.click", vecs[v].name), nc, vecs[v].n_click);
         check($sformatf("%s.double", vecs[v].name), nd, vecs[v].n_dbl);
         check($sformatf("%s.long", vecs[v].name), nl, vecs[v].n_long);
         check($sformatf("%s.first_at", vecs[v].name), first_at, vecs[v].first_at);
      end

      // Reset in the middle of a double-click attempt
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      check("midrst_pulses", {press_pulse, release_pulse, click_pulse, double_pulse, long_pulse}, 0);
      check("midrst_pressed", pressed, 1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      check("midrst_release", release_pulse, 1);
      check("midrst_no_double", double_pulse, 0);
      seen = 0;
      for (int k = 0; k < 15; k++) begin
         step(1'b0, 1'b0);
         seen += click_pulse + double_pulse + long_pulse;
      end
      check("midrst_quiet", seen, 0);
      first_at = -1;
      for (int c = 0; c < 15; c++) begin
         step(1'b0, c < 3);
         if (first_at < 0 && click_pulse) first_at = c;
      end
      check("post_rst_click_at", first_at, 3 + G);

      // Randomized run-length stimulus against the gesture model
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      n = 0;
      for (int k = 0; k < 3; k++) lv[n++] = 1'b0;
      while (n < 600) begin
         len = $urandom_range(L + 3, 1);
         for (int k = 0; k < len; k++) lv[n++] = 1'b1;
         len = $urandom_range(G + 3, 1);
         for (int k = 0; k < len; k++) lv[n++] = 1'b0;
      end
      for (int k = 0; k < 20; k++) lv[n++] = 1'b0;
      build_model();
      for (int t = 0; t < n; t++) begin
         step(1'b0, lv[t]);
         check($sformatf("rnd[%0d].pressed", t), pressed, lv[t]);
         check($sformatf("rnd[%0d].press", t), press_pulse, e_press[t]);
         check($sformatf("rnd[%0d].release", t), release_pulse, e_rel[t]);
         check($sformatf("rnd[%0d].click", t), click_pulse, e_click[t]);
         check($sformatf("rnd[%0d].double", t), double_pulse, e_dbl[t]);
         check($sformatf("rnd[%0d].long", t), long_pulse, e_long[t]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
